// File: rtl/def.sv
// Image-RAM address generator for the back-projection datapath.
// After a host kick and a P-cycle pipeline-fill delay, each partition
// sweeps its row strip in raster order and then its column strip in
// column-major order, until every partition has been covered.
module def #(
  parameter int IMAGE_SIZE       = 16,
  parameter int PARTITION_SIZE   = 4,
  parameter int NO_OF_PARTITIONS = 4,
  parameter int ADDR_W           = $clog2(IMAGE_SIZE * IMAGE_SIZE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hs_kick,
  input  logic              ir_enable,
  output logic              ir_kick,
  output logic              ir_done,
  output logic [ADDR_W-1:0] ir_addr
);

  localparam int PE_W   = (NO_OF_PARTITIONS > 1) ? $clog2(NO_OF_PARTITIONS) : 1;
  localparam int SCAN_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int LINE_W = (PARTITION_SIZE > 1) ? $clog2(PARTITION_SIZE) : 1;

  localparam logic [PE_W-1:0]   PE_LAST   = PE_W'(NO_OF_PARTITIONS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(IMAGE_SIZE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(PARTITION_SIZE - 1);

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMAGE_SIZE);
  localparam logic [ADDR_W-1:0] STRIP_X    = ADDR_W'(PARTITION_SIZE * IMAGE_SIZE);
  localparam logic [ADDR_W-1:0] STRIP_Y    = ADDR_W'(PARTITION_SIZE);

  typedef enum logic [1:0] {
    READY  = 2'd0,
    DELAY  = 2'd1,
    ADDR_X = 2'd2,
    ADDR_Y = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PE_W-1:0]    pe_pos_q, pe_pos_d;
  logic [SCAN_W-1:0]  scan_pos_q, scan_pos_d;
  logic [LINE_W-1:0]  line_pos_q, line_pos_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  off_x_q, off_x_d;
  logic [ADDR_W-1:0]  off_y_q, off_y_d;

  logic pe_done, scan_done, line_done;

  assign pe_done   = (pe_pos_q == PE_LAST);
  assign scan_done = (scan_pos_q == SCAN_LAST);
  assign line_done = (line_pos_q == LINE_LAST);

  assign ir_addr = base_q + ((state_q == ADDR_Y) ? off_y_q : off_x_q);

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= READY;
      pe_pos_q   <= '0;
      scan_pos_q <= '0;
      line_pos_q <= '0;
      base_q     <= '0;
      off_x_q    <= '0;
      off_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      pe_pos_q   <= pe_pos_d;
      scan_pos_q <= scan_pos_d;
      line_pos_q <= line_pos_d;
      base_q     <= base_d;
      off_x_q    <= off_x_d;
      off_y_q    <= off_y_d;
    end
  end

  // Next-state, counter update and pulse outputs.
  always_comb begin
    state_d    = state_q;
    pe_pos_d   = pe_pos_q;
    scan_pos_d = scan_pos_q;
    line_pos_d = line_pos_q;
    base_d     = base_q;
    off_x_d    = off_x_q;
    off_y_d    = off_y_q;
    ir_kick    = 1'b0;
    ir_done    = 1'b0;

    unique case (state_q)
      READY: begin
        pe_pos_d   = '0;
        scan_pos_d = '0;
        line_pos_d = '0;
        base_d     = '0;
        off_x_d    = '0;
        off_y_d    = '0;
        if (hs_kick) state_d = DELAY;
      end

      DELAY: begin
        pe_pos_d = pe_pos_q + 1'b1;
        if (pe_done) begin
          ir_kick  = 1'b1;
          pe_pos_d = '0;
          off_x_d  = '0;
          off_y_d  = '0;
          base_d   = '0;
          state_d  = ADDR_X;
        end
      end

      ADDR_X: begin
        if (ir_enable) begin
          scan_pos_d = scan_done ? '0 : scan_pos_q + 1'b1;
          if (scan_done) line_pos_d = line_done ? '0 : line_pos_q + 1'b1;
          base_d = base_q + 1'b1;
          if (scan_done && line_done) begin
            base_d  = '0;
            state_d = ADDR_Y;
          end
        end
      end

      ADDR_Y: begin
        if (ir_enable) begin
          scan_pos_d = scan_done ? '0 : scan_pos_q + 1'b1;
          if (scan_done) line_pos_d = line_done ? '0 : line_pos_q + 1'b1;
          // Column-major walk: step a row per scan, restart at the next
          // column of the strip when a column finishes.
          base_d = base_q + ROW_STEP;
          if (scan_done) base_d = ADDR_W'(line_pos_q) + 1'b1;
          if (scan_done && line_done) begin
            base_d   = '0;
            pe_pos_d = pe_pos_q + 1'b1;
            off_x_d  = off_x_q + STRIP_X;
            off_y_d  = off_y_q + STRIP_Y;
            if (pe_done) begin
              state_d = READY;
              ir_done = 1'b1;
            end else begin
              state_d = ADDR_X;
            end
          end
        end
      end

      default: state_d = READY;
    endcase
  end

endmodule

// File: tb/tb_def.sv
// Self-checking bench for def with N=4, S=2, P=2.
module tb_def;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int P    = 2;
  localparam int AW   = 4;
  localparam int RUNL = 2 * N * N;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hs_kick;
  logic          ir_enable;
  logic          ir_kick;
  logic          ir_done;
  logic [AW-1:0] ir_addr;

  int n_cmp = 0;
  int n_bad = 0;

  def #(
    .IMAGE_SIZE      (N),
    .PARTITION_SIZE  (S),
    .NO_OF_PARTITIONS(P),
    .ADDR_W          (AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hs_kick  (hs_kick),
    .ir_enable(ir_enable),
    .ir_kick  (ir_kick),
    .ir_done  (ir_done),
    .ir_addr  (ir_addr)
  );

  always #5 clk = ~clk;

  int lit [RUNL] = '{0, 1, 2, 3, 4, 5, 6, 7,
                     0, 4, 8, 12, 1, 5, 9, 13,
                     8, 9, 10, 11, 12, 13, 14, 15,
                     2, 6, 10, 14, 3, 7, 11, 15};

  int expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address list built from the strip definitions.
  function automatic void build_model();
    expq.delete();
    for (int pe = 0; pe < P; pe++) begin
      for (int i = 0; i < S * N; i++) expq.push_back(pe * S * N + i);
      for (int ln = 0; ln < S; ln++)
        for (int sc = 0; sc < N; sc++) expq.push_back(pe * S + ln + sc * N);
    end
  endfunction

  // Behavioural timing model: idle / fill delay / streaming index.
  typedef enum int {M_IDLE, M_DELAY, M_RUN} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_dcnt = 0;
  int    m_idx  = 0;
  bit    m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_mode  <= M_IDLE;
      m_valid <= 1'b1;
    end else begin
      case (m_mode)
        M_IDLE:  if (hs_kick) begin m_mode <= M_DELAY; m_dcnt <= 0; end
        M_DELAY: if (m_dcnt == P - 1) begin m_mode <= M_RUN; m_idx <= 0; end
                 else m_dcnt <= m_dcnt + 1;
        M_RUN:   if (ir_enable) begin
                   if (m_idx == RUNL - 1) m_mode <= M_IDLE;
                   else m_idx <= m_idx + 1;
                 end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_addr", 32'(ir_addr), (m_mode == M_RUN) ? expq[m_idx] : 0);
      check("model_kick", 32'(ir_kick), 32'(m_mode == M_DELAY && m_dcnt == P - 1));
      check("model_done", 32'(ir_done), 32'(m_mode == M_RUN && m_idx == RUNL - 1 && ir_enable));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse hs_kick, then expect ir_kick on the second cycle after the kick cycle.
  task automatic kick_and_wait();
    int cnt;
    hs_kick = 1'b1;
    step();
    hs_kick = 1'b0;
    cnt = 0;
    while (ir_kick !== 1'b1 && cnt < 10) begin
      step();
      cnt++;
    end
    check("kick_latency", 32'(cnt), 32'd1);
    step();
  endtask

  // Stream a full run against the literal table; optional stall and spurious kick.
  task automatic run_stream(input int stall_at, input int spur_at);
    for (int i = 0; i < RUNL; i++) begin
      if (i == stall_at) begin
        ir_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check("stall_hold", 32'(ir_addr), 32'(lit[i]));
          check("stall_no_done", 32'(ir_done), 32'd0);
          step();
        end
        ir_enable = 1'b1;
      end
      if (i == spur_at) hs_kick = 1'b1;
      check("lit_addr", 32'(ir_addr), 32'(lit[i]));
      check("lit_done", 32'(ir_done), 32'(i == RUNL - 1));
      step();
      hs_kick = 1'b0;
    end
    check("ready_addr", 32'(ir_addr), 32'd0);
    check("ready_done", 32'(ir_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    build_model();
    check("model_len", 32'(expq.size()), 32'(RUNL));
    for (int i = 0; i < RUNL; i++) check("model_pin", 32'(expq[i]), 32'(lit[i]));

    reset_n   = 1'b0;
    hs_kick   = 1'b1;
    ir_enable = 1'b1;
    step();
    step();
    check("rst_addr", 32'(ir_addr), 32'd0);
    check("rst_kick", 32'(ir_kick), 32'd0);
    check("rst_done", 32'(ir_done), 32'd0);
    hs_kick = 1'b0;
    reset_n = 1'b1;
    step();
    check("idle_addr", 32'(ir_addr), 32'd0);
    check("idle_kick", 32'(ir_kick), 32'd0);

    kick_and_wait();
    run_stream(-1, -1);

    kick_and_wait();
    run_stream(13, 20);

    kick_and_wait();
    for (int i = 0; i < 19; i++) begin
      check("pre_reset_addr", 32'(ir_addr), 32'(lit[i]));
      step();
    end
    reset_n = 1'b0;
    step();
    check("midrst_addr", 32'(ir_addr), 32'd0);
    check("midrst_kick", 32'(ir_kick), 32'd0);
    check("midrst_done", 32'(ir_done), 32'd0);
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_idle", 32'(ir_addr), 32'd0);

    kick_and_wait();
    run_stream(-1, -1);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/def.md
# def

Image-RAM address generator for the back-projection datapath. It sits between the host kick and the image RAM. On a kick it waits a fixed pipeline-fill delay, then emits the address stream that matches values leaving the PE domino chain. For each partition (PE) it sweeps that partition's row strip in raster order, then its column strip in column-major order, and repeats until every partition is done.

## Interface
Parameters:
- IMAGE_SIZE, default 16: image is N×N pixels.
- PARTITION_SIZE, default 4: strip width S in rows/columns.
- NO_OF_PARTITIONS, default 4: number of PEs P. Requires P×S = N.
- ADDR_W, default clog2(IMAGE_SIZE²): address width.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- reset_n, input, 1: reset, synchronous, active-low.
- hs_kick, input, 1: host start pulse. Sampled only in READY.
- ir_enable, input, 1: image RAM accepts the current address. Advances addressing and acts as a stall when low.
- ir_kick, output, 1: one-cycle pulse on the last DELAY cycle.
- ir_done, output, 1: one-cycle pulse concurrent with the final address of the run.
- ir_addr, output, ADDR_W: current image address.

## Operation
- States: READY, DELAY, ADDR_X, ADDR_Y.
- Registers: pe_pos (0..P-1), scan_pos (0..N-1), line_pos (0..S-1), base, off_x, off_y. All address-width registers are ADDR_W bits, with modulo-2^ADDR_W arithmetic.
- Address output: ir_addr = base + (state==ADDR_Y ? off_y : off_x). This is combinational from registers.
- Flags:
  - pe_done = (pe_pos==P-1)
  - scan_done = (scan_pos==N-1)
  - line_done = (line_pos==S-1)
- READY:
  - Every register is cleared to 0 each cycle.
  - hs_kick=1 → DELAY.
- DELAY:
  - pe_pos increments each cycle, independent of ir_enable.
  - When pe_done, ir_kick=1 and pe_pos, off_x, off_y, base are cleared → ADDR_X.
- ADDR_X, advancing only when ir_enable=1:
  - scan_pos increments and wraps to 0 on scan_done.
  - line_pos increments on scan_done and wraps to 0 on scan_done&&line_done.
  - base increments by 1, or is set to 0 on scan_done&&line_done.
  - On scan_done&&line_done → ADDR_Y.
  - Resulting sequence: off_x + 0 … off_x + S·N−1.
- ADDR_Y, advancing only when ir_enable=1, with the same scan/line counting as ADDR_X:
  - base increments by N.
  - On scan_done only, base is set to line_pos+1.
  - On scan_done&&line_done, base is set to 0.
  - Resulting sequence: off_y + line + scan·N, for line 0..S-1 in the outer loop and scan 0..N-1 in the inner loop.
- End of ADDR_Y (ir_enable && scan_done && line_done):
  - pe_pos += 1, off_x += S·N, off_y += S.
  - If pe_done (evaluated before the increment) → READY with ir_done=1; otherwise → ADDR_X.
- ir_done = (state==ADDR_Y && next_state==READY).
- ir_enable=0 in ADDR_X or ADDR_Y:
  - All counters and addresses hold.
  - ir_addr stays stable.
  - No transition occurs.
- hs_kick outside READY is ignored. A run cannot be restarted except by reset.
- Reset (reset_n=0 at a clock edge, including mid-run): state becomes READY and all registers are cleared. After that edge, ir_addr=0, ir_kick=0, ir_done=0.

## Timing
- Kick latency: hs_kick seen in READY at edge k puts the block in DELAY after edge k.
- DELAY lasts exactly P cycles. ir_kick is high during the P-th cycle, and ADDR_X starts on the next cycle.
- In ADDR_X/ADDR_Y, one address is consumed per cycle with ir_enable=1.
- A full run is 2·N·N enabled cycles: S·N per strip, two strips per PE, P PEs.
- Strip transitions (X→Y, Y→X, Y→READY) add no bubble cycles.
- ir_done is asserted in the same cycle that the final address (N²−1 when S·P=N) is presented. The block is in READY on the next cycle.

## Test plan
- Use N=4, S=2, P=2, ADDR_W=4 for all scenarios unless stated.
- Reset: hold reset_n=0 for 2 cycles → ir_addr=0, ir_kick=0, ir_done=0, and hs_kick has no effect during reset.
- Kick with ir_enable=1: pulse hs_kick → ir_kick high exactly 2 cycles after the kick cycle; then ir_addr sequence 0–7; then 0,4,8,12,1,5,9,13; then 8–15; then 2,6,10,14,3,7,11,15 → ir_done high only with the final 15.
- Stall: drop ir_enable for 3 cycles at address 5 in the first ADDR_Y strip → ir_addr holds 5 for those cycles, and the sequence then resumes at 9 with nothing skipped or repeated.
- Spurious kick: pulse hs_kick mid-run → sequence unchanged, with no restart.
- Mid-run reset: assert reset_n=0 during the second PE's X strip → READY, ir_addr=0; a new kick then reproduces the full sequence from 0.
- Back-to-back runs: assert hs_kick in the first READY cycle after ir_done → second run is identical, with offsets restarting at 0.
